// File: rtl/hwpe_ctrl_package.sv
// Shared constants and types for the reqrsp-to-periph bridge.
// Counters are sized for the largest supported response buffer.
package hwpe_ctrl_package;

  localparam int unsigned REQRSP2PERIPH_MAX_DEPTH = 8;
  localparam int unsigned REQRSP2PERIPH_ID_WIDTH  = 2;
  localparam int unsigned REQRSP2PERIPH_CNT_W     = $clog2(REQRSP2PERIPH_MAX_DEPTH + 1);

  typedef logic [REQRSP2PERIPH_CNT_W-1:0] r2p_cnt_t;

  // Every granted request holds one credit until its response is popped.
  function automatic r2p_cnt_t r2p_credits(input r2p_cnt_t outstanding, input r2p_cnt_t buffered);
    return outstanding + buffered;
  endfunction

endpackage

// File: rtl/hwpe_ctrl_intf_periph.sv
// Peripheral port: req/gnt request handshake, r_valid response with no backpressure.
// wen=1 marks a read; id travels with the request and returns as r_id.
interface hwpe_ctrl_intf_periph #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned ID_WIDTH = 2
) ();

  logic                req;
  logic                gnt;
  logic [AW-1:0]       add;
  logic                wen;
  logic [DW/8-1:0]     be;
  logic [DW-1:0]       data;
  logic [ID_WIDTH-1:0] id;
  logic [DW-1:0]       r_data;
  logic                r_valid;
  logic [ID_WIDTH-1:0] r_id;

  modport master (
    output req, add, wen, be, data, id,
    input  gnt, r_data, r_valid, r_id
  );

  modport slave (
    input  req, add, wen, be, data, id,
    output gnt, r_data, r_valid, r_id
  );

endinterface

// File: rtl/hwpe_ctrl_intf_reqrsp.sv
// Request/response channel: q_* carries the request, p_* the response.
// Both directions use valid/ready handshakes.
interface hwpe_ctrl_intf_reqrsp #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) ();

  logic          q_valid;
  logic          q_ready;
  logic [AW-1:0] q_addr;
  logic          q_write;
  logic [DW-1:0] q_data;
  logic [DW/8-1:0] q_strb;
  logic          p_valid;
  logic          p_ready;
  logic [DW-1:0] p_data;

  modport initiator (
    output q_valid, q_addr, q_write, q_data, q_strb, p_ready,
    input  q_ready, p_valid, p_data
  );

  modport target (
    input  q_valid, q_addr, q_write, q_data, q_strb, p_ready,
    output q_ready, p_valid, p_data
  );

endinterface

// File: rtl/hwpe_ctrl_reqrsp2periph_fifo.sv
// Registered response FIFO, DEPTH entries, one cycle from push to pop visibility.
// Push while full is accepted only together with a pop; pop while empty is ignored.
module hwpe_ctrl_reqrsp2periph_fifo
  import hwpe_ctrl_package::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [DW-1:0] push_dat_i,
  input  logic          pop_i,
  output logic [DW-1:0] pop_dat_o,
  output logic          full_o,
  output logic          empty_o,
  output r2p_cnt_t      count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  r2p_cnt_t         count_q;
  logic             do_push, do_pop;

  assign full_o    = (count_q == r2p_cnt_t'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign pop_dat_o = mem[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + r2p_cnt_t'(do_push) - r2p_cnt_t'(do_pop);
    end
  end

  // Storage carries no reset; empty_o guards every read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/hwpe_ctrl_reqrsp2periph.sv
// Bridges a reqrsp target onto a periph master; responses are buffered in order, visible 1 cycle after r_valid.
// req is withheld while DEPTH credits are used; define HWPE_CTRL_REQRSP2PERIPH_IDCHK_EN for id tagging and err_o.
module hwpe_ctrl_reqrsp2periph
  import hwpe_ctrl_package::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned ID_WIDTH = REQRSP2PERIPH_ID_WIDTH,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  hwpe_ctrl_intf_reqrsp.target        slave,
  hwpe_ctrl_intf_periph.master        master,
  output logic                        err_o
);

  logic          grant, accept, fifo_pop;
  logic          fifo_full, fifo_empty;
  r2p_cnt_t      outstanding_q, fifo_count, credits;
  logic [AW-1:0] req_add;
  logic [DW-1:0] req_dat, rsp_dat;

  assign credits = r2p_credits(outstanding_q, fifo_count);

  assign master.req  = slave.q_valid & (credits < r2p_cnt_t'(DEPTH));
  assign grant       = master.req & master.gnt;
  assign slave.q_ready = grant;

  assign req_add     = slave.q_addr;
  assign req_dat     = slave.q_data;
  assign master.add  = req_add;
  assign master.data = req_dat;
  assign master.be   = slave.q_strb;
  assign master.wen  = ~slave.q_write;

  // A response with nothing outstanding belongs to an abandoned request.
  assign accept = master.r_valid & (outstanding_q != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
    end else if (grant & ~accept) begin
      outstanding_q <= outstanding_q + r2p_cnt_t'(1);
    end else if (~grant & accept) begin
      outstanding_q <= outstanding_q - r2p_cnt_t'(1);
    end
  end

  assign fifo_pop      = slave.p_ready & ~fifo_empty;
  assign slave.p_valid = ~fifo_empty;
  assign slave.p_data  = rsp_dat;

  hwpe_ctrl_reqrsp2periph_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) i_rsp_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (accept),
    .push_dat_i (master.r_data),
    .pop_i      (fifo_pop),
    .pop_dat_o  (rsp_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  // Credit gating reserves a slot for every outstanding response.
  assert property (@(posedge clk_i) disable iff (rst_i) accept |-> (~fifo_full | fifo_pop));
  assert property (@(posedge clk_i) disable iff (rst_i) credits <= r2p_cnt_t'(DEPTH));

`ifdef HWPE_CTRL_REQRSP2PERIPH_IDCHK_EN
  logic [ID_WIDTH-1:0] issue_tag_q, expect_tag_q;
  logic                err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      issue_tag_q  <= '0;
      expect_tag_q <= '0;
      err_q        <= 1'b0;
    end else begin
      if (grant)  issue_tag_q  <= issue_tag_q + ID_WIDTH'(1);
      if (accept) expect_tag_q <= expect_tag_q + ID_WIDTH'(1);
      if ((master.r_valid & (outstanding_q == '0)) |
          (accept & (master.r_id != expect_tag_q))) begin
        err_q <= 1'b1;
      end
    end
  end

  assign master.id = issue_tag_q;
  assign err_o     = err_q;
`else
  logic [ID_WIDTH-1:0] unused_r_id;

  assign unused_r_id = master.r_id;
  assign master.id   = '0;
  assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_hwpe_ctrl_reqrsp2periph.sv
// Scoreboard bench: issued requests push expected periph beats and responses; a negedge monitor checks them.
// Build with HWPE_CTRL_REQRSP2PERIPH_IDCHK_EN to also check id tagging and err_o.
module tb_hwpe_ctrl_reqrsp2periph;

  localparam int unsigned DEPTH = 2;
`ifdef HWPE_CTRL_REQRSP2PERIPH_IDCHK_EN
  localparam bit IDCHK = 1'b1;
`else
  localparam bit IDCHK = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] add;
    logic [31:0] data;
    logic [3:0]  be;
    logic        wen;
  } req_t;

  logic clk = 1'b0;
  logic rst;
  logic err;
  always #5 clk = ~clk;

  hwpe_ctrl_intf_reqrsp #(.AW(32), .DW(32)) rr ();
  hwpe_ctrl_intf_periph #(.AW(32), .DW(32), .ID_WIDTH(2)) pp ();

  hwpe_ctrl_reqrsp2periph #(
    .AW(32), .DW(32), .ID_WIDTH(2), .DEPTH(DEPTH)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .slave  (rr),
    .master (pp),
    .err_o  (err)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_grants = 0;
  int          n_issued = 0;
  int          n_sent = 0;
  int          corrupt_at;
  bit          rsp_hold;
  logic [1:0]  tag_model = '0;

  req_t        req_exp_q[$];
  logic [31:0] plan_q[$];
  logic [31:0] p_exp_q[$];
  logic [31:0] pend_d[$];
  logic [1:0]  pend_id[$];
  string       chk_name_q[$];
  logic [31:0] chk_act_q[$];
  logic [31:0] chk_exp_q[$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Direct checks are queued and scored by the monitor, the only process touching the counters.
  task automatic expect_now(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_name_q.push_back(name);
    chk_act_q.push_back(act);
    chk_exp_q.push_back(exp);
  endtask

  always @(negedge clk) begin
    req_t e;
    if (rst) begin
      tag_model = '0;
    end else begin
      if (pp.req && pp.gnt) begin
        n_grants++;
        if (req_exp_q.size() == 0) begin
          cmp("unexpected_grant", 32'd1, 32'd0);
        end else begin
          e = req_exp_q.pop_front();
          cmp("req_add", pp.add, e.add);
          cmp("req_data", pp.data, e.data);
          cmp("req_be", 32'(pp.be), 32'(e.be));
          cmp("req_wen", 32'(pp.wen), 32'(e.wen));
          cmp("req_id", 32'(pp.id), IDCHK ? 32'(tag_model) : 32'd0);
        end
        if (plan_q.size() > 0) begin
          pend_d.push_back(plan_q.pop_front());
          pend_id.push_back(pp.id);
        end
        tag_model = tag_model + 2'd1;
      end
      if (rr.p_valid && rr.p_ready) begin
        if (p_exp_q.size() == 0) cmp("unexpected_p_beat", 32'd1, 32'd0);
        else                     cmp("p_data", rr.p_data, p_exp_q.pop_front());
      end
    end
    while (chk_name_q.size() > 0)
      cmp(chk_name_q.pop_front(), chk_act_q.pop_front(), chk_exp_q.pop_front());
  end

  // Peripheral model: answers each grant one cycle later, optionally corrupting one r_id.
  always @(posedge clk) begin
    #1;
    if (!rsp_hold && pend_d.size() > 0) begin
      pp.r_valid = 1'b1;
      pp.r_data  = pend_d.pop_front();
      pp.r_id    = pend_id.pop_front();
      if (n_sent == corrupt_at) pp.r_id = 2'd2;
      n_sent++;
    end else begin
      pp.r_valid = 1'b0;
      pp.r_data  = '0;
      pp.r_id    = '0;
    end
  end

  task automatic issue(input logic [31:0] addr, input logic [31:0] wdat, input logic wr,
                       input logic [3:0] strb, input logic [31:0] rdat, input bit keep);
    req_t e;
    e.add = addr; e.data = wdat; e.be = strb; e.wen = ~wr;
    req_exp_q.push_back(e);
    plan_q.push_back(rdat);
    if (keep) p_exp_q.push_back(rdat);
    n_issued++;
    rr.q_valid = 1'b1; rr.q_addr = addr; rr.q_data = wdat; rr.q_write = wr; rr.q_strb = strb;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rr.q_ready) begin
        @(posedge clk); #1;
        rr.q_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    expect_now("issue_timeout", 32'd1, 32'd0);
    rr.q_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (p_exp_q.size() == 0 && pend_d.size() == 0) begin
        @(posedge clk); #1;
        return;
      end
    end
    expect_now("drain_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(negedge clk);
    expect_now("err_after_reset", err, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g0;
    rst = 1'b1; rsp_hold = 1'b0; corrupt_at = -1;
    rr.q_valid = 1'b0; rr.q_addr = '0; rr.q_write = 1'b0; rr.q_data = '0; rr.q_strb = '0;
    rr.p_ready = 1'b0; pp.gnt = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    expect_now("rst_p_valid", rr.p_valid, 32'd0);
    expect_now("rst_req", pp.req, 32'd0);
    expect_now("rst_q_ready", rr.q_ready, 32'd0);
    expect_now("rst_id", 32'(pp.id), 32'd0);
    expect_now("rst_err", err, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single read: r_valid one cycle after grant, p_valid one cycle after that.
    rr.p_ready = 1'b1;
    issue(32'h10, 32'h0, 1'b0, 4'hF, 32'hCAFE0001, 1'b1);
    @(negedge clk);
    expect_now("no_bypass", rr.p_valid, 32'd0);
    @(negedge clk);
    expect_now("p_latency", rr.p_valid, 32'd1);
    expect_now("err_single", err, 32'd0);
    @(posedge clk); #1;

    // Write mapping: wen=0, be follows strobe; still one response beat.
    issue(32'h100, 32'h5A5A5A5A, 1'b1, 4'h3, 32'h00000031, 1'b1);
    drain();

    // Request held by the peripheral: req high but no handshake without gnt.
    pp.gnt = 1'b0;
    fork
      issue(32'h300, 32'h0, 1'b0, 4'hF, 32'h33330001, 1'b1);
      begin
        repeat (2) begin
          @(negedge clk);
          expect_now("stall_req", pp.req, 32'd1);
          expect_now("stall_q_ready", rr.q_ready, 32'd0);
        end
        @(posedge clk); #1;
        pp.gnt = 1'b1;
      end
    join
    drain();

    // Credit exhaustion: third read waits until one response is popped.
    rr.p_ready = 1'b0;
    g0 = n_grants;
    issue(32'h400, 32'h0, 1'b0, 4'hF, 32'hA0000001, 1'b1);
    issue(32'h404, 32'h0, 1'b0, 4'hF, 32'hB0000002, 1'b1);
    fork
      issue(32'h408, 32'h0, 1'b0, 4'hF, 32'hC0000003, 1'b1);
      begin
        repeat (4) begin
          @(negedge clk);
          expect_now("req_gated", pp.req, 32'd0);
        end
        expect_now("grants_while_full", 32'(n_grants - g0), 32'd2);
        @(posedge clk); #1;
        rr.p_ready = 1'b1;
      end
    join
    drain();

    // Push of a new response and pop of the head in the same cycle.
    rr.p_ready = 1'b0;
    issue(32'h500, 32'h0, 1'b0, 4'hF, 32'hD0000004, 1'b1);
    issue(32'h504, 32'h0, 1'b0, 4'hF, 32'hE0000005, 1'b1);
    rr.p_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    expect_now("simul_push_pop", rr.p_valid, 32'd1);
    @(posedge clk); #1;
    drain();

    // Reset with one read in flight; its late response must vanish.
    rsp_hold = 1'b1;
    issue(32'h600, 32'h0, 1'b0, 4'hF, 32'hDEAD0034, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_hold = 1'b0;
    repeat (4) begin
      @(negedge clk);
      expect_now("abandoned_p_valid", rr.p_valid, 32'd0);
    end
    expect_now("abandoned_err", err, IDCHK ? 32'd1 : 32'd0);
    @(posedge clk); #1;
    drain();
    do_reset();

    // Five reads with ids 0,1,2,3,0; first response returns r_id=2.
    corrupt_at = n_issued;
    for (int i = 0; i < 5; i++)
      issue(32'h700 + 32'(4 * i), 32'h0, 1'b0, 4'hF, 32'h70000000 + 32'(i), 1'b1);
    drain();
    expect_now("err_set", err, IDCHK ? 32'd1 : 32'd0);
    issue(32'h800, 32'h0, 1'b1, 4'hC, 32'h80000008, 1'b1);
    drain();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    expect_now("err_sticky", err, IDCHK ? 32'd1 : 32'd0);
    @(posedge clk); #1;
    do_reset();

    expect_now("scoreboard_empty", 32'(p_exp_q.size() + req_exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
